// File: rtl/frame_buf_sched.sv
// frame_buf_sched: two-field video capture into a single-port frame memory with read arbitration.
// Capture writes own the memory port; reads get any idle cycle while mode is capture+read.
module frame_buf_sched #(
  parameter int H_ACTIVE = 702,
  parameter int V_ACTIVE = 288
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic        video_frame_valid,
  input  logic        video_line_valid,
  input  logic        video_data_valid,
  input  logic [7:0]  video_data_in,
  input  logic [19:0] video_address,
  output logic        mem_we,
  output logic [19:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        rd_req,
  input  logic [19:0] rd_addr,
  output logic        rd_gnt,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        frame_ack,
  output logic        frame_ready,
  output logic        field_err
);
  localparam logic [17:0] PIX   = 18'(H_ACTIVE * V_ACTIVE);
  localparam logic [8:0]  LINES = 9'(V_ACTIVE);

  typedef enum logic [2:0] {IDLE, WAIT_F0, CAP_F0, WAIT_F1, CAP_F1, READY} state_t;

  state_t      r_state, w_next;
  logic        r_fv, r_lv, r_mis, r_pend, r_rd_valid;
  logic [17:0] r_pix;
  logic [8:0]  r_lines;
  logic [19:0] r_waddr;
  logic [7:0]  r_wdata, r_rd_hold;
  logic        w_active, w_fv_rise, w_fv_fall, w_lv_rise, w_cap, w_fld_ok, w_wr, w_ok, w_gnt, w_ferr;

  assign w_active  = mode == 2'b01 || mode == 2'b10;
  assign w_fv_rise = video_frame_valid & ~r_fv;
  assign w_fv_fall = ~video_frame_valid & r_fv;
  assign w_lv_rise = video_line_valid & ~r_lv;
  assign w_cap     = w_active && (r_state == CAP_F0 || r_state == CAP_F1);
  assign w_fld_ok  = video_address[10] == (r_state == CAP_F1);
  assign w_wr      = w_cap && video_data_valid && w_fld_ok;
  assign w_ok      = r_pix == PIX && r_lines == LINES && !r_mis;
  assign w_gnt     = rd_req && mode == 2'b01 && r_state != IDLE && !r_pend;

  always_comb begin
    w_next = r_state;
    w_ferr = 1'b0;
    if (!w_active)
      w_next = IDLE;
    else
      case (r_state)
        IDLE:    w_next = WAIT_F0;
        WAIT_F0: w_next = w_fv_rise ? CAP_F0 : WAIT_F0;
        CAP_F0: begin
          w_next = w_fv_fall ? (w_ok ? WAIT_F1 : WAIT_F0) : CAP_F0;
          w_ferr = w_fv_fall && !w_ok;
        end
        WAIT_F1: w_next = w_fv_rise ? CAP_F1 : WAIT_F1;
        CAP_F1: begin
          w_next = w_fv_fall ? (w_ok ? READY : WAIT_F0) : CAP_F1;
          w_ferr = w_fv_fall && !w_ok;
        end
        READY:   w_next = (frame_ack || w_fv_rise) ? WAIT_F0 : READY;
        default: w_next = IDLE;
      endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fv       <= 1'b0;
      r_lv       <= 1'b0;
      r_pix      <= '0;
      r_lines    <= '0;
      r_mis      <= 1'b0;
      r_pend     <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_hold  <= '0;
    end else begin
      r_state    <= w_next;
      r_fv       <= video_frame_valid;
      r_lv       <= video_line_valid;
      // counters stay cleared outside capture, so every capture starts from zero
      r_pix      <= w_cap ? r_pix + 18'(video_data_valid && r_pix != '1) : '0;
      r_lines    <= w_cap ? r_lines + 9'(w_lv_rise && r_lines != '1) : '0;
      r_mis      <= w_cap && (r_mis || (video_data_valid && !w_fld_ok));
      r_pend     <= w_wr;
      r_rd_valid <= w_gnt;
      if (w_wr) begin
        r_waddr <= video_address;
        r_wdata <= video_data_in;
      end
      if (r_rd_valid) r_rd_hold <= mem_rdata;
    end
  end

  assign mem_we      = r_pend;
  assign mem_addr    = r_pend ? r_waddr : w_gnt ? rd_addr : '0;
  assign mem_wdata   = r_wdata;
  assign rd_gnt      = w_gnt;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_valid ? mem_rdata : r_rd_hold;
  assign frame_ready = r_state == READY;
  assign field_err   = w_ferr;
endmodule
